decstage_pipe: RTL

- Parametrised, pipelined successor to the single-cycle decode stage of the CHARIS-style datapath.
- Holds the register file and immediate generator, and registers decoded operands into an ID/EX output register with valid/ready handshake.
- Adds write-back bypass, load-use hazard bubbles, a LUI immediate mode and a saturating stall counter.
- Sits between fetch (IF/ID) and execute stages.

---
 rtl/decstage_pipe_pkg.sv | 39 +++
 rtl/decstage_pipe_regfile_bypass.sv | 47 ++++
 rtl/decstage_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/decstage_pipe_pkg.sv
// Shared decode definitions for the pipelined decode stage: opcode values,
// immediate-extension modes and opcode classification helpers.
package decstage_pipe_pkg;

  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LUI  = 6'b111001;

  typedef enum logic [1:0] {
    IMM_SEXT,
    IMM_ZERO,
    IMM_SEXT_SH2,
    IMM_LUI
  } imm_mode_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LW);
  endfunction

  // Unlisted opcodes fall back to zero-fill.
  function automatic imm_mode_e imm_mode(input logic [5:0] op);
    case (op)
      OP_LI, OP_ADDI, OP_LB, OP_SB, OP_LW, OP_SW: return IMM_SEXT;
      OP_B, OP_BEQ, OP_BNE:                       return IMM_SEXT_SH2;
      OP_LUI:                                     return IMM_LUI;
      default:                                    return IMM_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/decstage_pipe_regfile_bypass.sv
// Register file with R0 hardwired to zero, one synchronous write port and two
// combinational read ports; optional write-first bypass from the write port.
module regfile_bypass #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_EN = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam bit BYP = (BYPASS_EN != 0);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage: cleared on reset, R0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port A: R0 reads zero, in-flight write wins when bypass is enabled.
  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == '0)                      rdata_a = '0;
    else if (BYP && we && waddr == raddr_a) rdata_a = wdata;
  end

  // Read port B: same rules as port A.
  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == '0)                      rdata_b = '0;
    else if (BYP && we && waddr == raddr_b) rdata_b = wdata;
  end

endmodule

// File: rtl/decstage_pipe.sv
// Pipelined decode stage: register file read, immediate extension and an
// ID/EX register with valid/ready handshake, load-use bubbles and a
// saturating count of bubble cycles.
module decstage_pipe
  import decstage_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_EN = 1,
  parameter int CNT_W     = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [31:0]       Instr,
  input  logic              RF_B_sel,
  input  logic              WB_WrEn,
  input  logic [ADDR_W-1:0] WB_Addr,
  input  logic              WB_Sel,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Immed,
  output logic [DATA_W-1:0] Out_RF_A,
  output logic [DATA_W-1:0] Out_RF_B,
  output logic [ADDR_W-1:0] Out_Rd,
  output logic [5:0]        Out_Opcode,
  output logic              Out_IsLoad,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [5:0] op,
                                                       input logic [15:0] imm);
    logic signed [DATA_W-1:0] sx;
    sx = {{(DATA_W-16){imm[15]}}, imm};
    case (imm_mode(op))
      IMM_SEXT:     return sx;
      IMM_SEXT_SH2: return sx <<< 2;
      IMM_LUI:      return sx <<< 16;
      default:      return {{(DATA_W-16){1'b0}}, imm};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [5:0]        opc;
  logic [ADDR_W-1:0] rs_addr, rb_addr, rd_addr;
  logic [DATA_W-1:0] wb_data, rf_a, rf_b;
  logic              wb_we, accept, hazard;

  logic              vld_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0] rfa_p1, rfb_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic [5:0]        opc_p1;
  logic              isload_p1;
  logic [CNT_W-1:0]  stall_cnt;

  assign opc     = Instr[31:26];
  assign rs_addr = Instr[21 +: ADDR_W];
  assign rd_addr = Instr[16 +: ADDR_W];
  assign rb_addr = RF_B_sel ? Instr[16 +: ADDR_W] : Instr[11 +: ADDR_W];

  // No register-file write lands in a reset cycle.
  assign wb_we   = WB_WrEn & ~Rst;
  assign wb_data = WB_Sel ? MEM_out : ALU_out;

  regfile_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS_EN(BYPASS_EN)
  ) u_rf (
    .clk    (Clk),
    .rst    (Rst),
    .we     (wb_we),
    .waddr  (WB_Addr),
    .wdata  (wb_data),
    .raddr_a(rs_addr),
    .raddr_b(rb_addr),
    .rdata_a(rf_a),
    .rdata_b(rf_b)
  );

  // Load in ID/EX whose destination feeds this instruction forces one bubble.
  assign accept   = Out_Ready | ~vld_p1;
  assign hazard   = In_Valid & vld_p1 & isload_p1 & (rd_p1 != '0) &
                    ((rd_p1 == rs_addr) | (rd_p1 == rb_addr));
  assign In_Ready = accept & ~hazard;

  // ---- stage p0 -> p1: ID/EX register ----
  // Capture decode on a free slot, insert a bubble on a hazard, hold otherwise.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p1    <= 1'b0;
      imm_p1    <= '0;
      rfa_p1    <= '0;
      rfb_p1    <= '0;
      rd_p1     <= '0;
      opc_p1    <= '0;
      isload_p1 <= 1'b0;
      stall_cnt <= '0;
    end else if (accept) begin
      if (hazard) begin
        vld_p1    <= 1'b0;
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        vld_p1    <= In_Valid;
        imm_p1    <= ext_imm(opc, Instr[15:0]);
        rfa_p1    <= rf_a;
        rfb_p1    <= rf_b;
        rd_p1     <= rd_addr;
        opc_p1    <= opc;
        isload_p1 <= is_load(opc);
      end
    end
  end

  assign Out_Valid  = vld_p1;
  assign Out_Immed  = imm_p1;
  assign Out_RF_A   = rfa_p1;
  assign Out_RF_B   = rfb_p1;
  assign Out_Rd     = rd_p1;
  assign Out_Opcode = opc_p1;
  assign Out_IsLoad = isload_p1;
  assign Stall_Cnt  = stall_cnt;

endmodule
